// File: rtl/regfile_param.sv
// Parameterised 2R1W register file with registered read ports,
// optional write bypass, optional zero register and post-reset init sequencer.
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW,
  input  logic              EnW,
  input  logic [DATA_W-1:0] BusW,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  output logic              init_busy
);

  localparam int LAST = NUM_REGS - 1;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_busy_q, init_busy_d;
  logic [DATA_W-1:0] bus_a_q, bus_a_d;
  logic [DATA_W-1:0] bus_b_q, bus_b_d;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              run_we;
  logic [DATA_W-1:0] init_val;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Read mux sees the pre-write array; bypass only for writes that land.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if (!in_range(a) || is_zero(a)) return '0;
    if ((BYPASS != 0) && run_we && (RW == a)) return BusW;
    return regs_q[a];
  endfunction

  assign run_we = EnW && in_range(RW) && !is_zero(RW);

  assign init_val = is_zero(init_cnt_q) ? '0
                  : DATA_W'(init_cnt_q) + DATA_W'(1);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_busy_d = init_busy_q;
    bus_a_d     = bus_a_q;
    bus_b_d     = bus_b_q;
    we          = 1'b0;
    wa          = RW;
    wd          = BusW;
    unique case (state_q)
      INIT: begin
        we         = 1'b1;
        wa         = init_cnt_q;
        wd         = init_val;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (32'(init_cnt_q) == 32'(LAST)) begin
          state_d     = RUN;
          init_busy_d = 1'b0;
          init_cnt_d  = '0;
        end
      end
      RUN: begin
        we = run_we;
        if (En) begin
          bus_a_d = rd(RA);
          bus_b_d = rd(RB);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_busy_q <= 1'b1;
      bus_a_q     <= '0;
      bus_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_busy_q <= init_busy_d;
      bus_a_q     <= bus_a_d;
      bus_b_q     <= bus_b_d;
    end
  end

  // Array has no reset; the init sequencer defines its contents.
  always_ff @(posedge clk) begin
    if (!rst && we) regs_q[wa] <= wd;
  end

  assign BusA      = bus_a_q;
  assign BusB      = bus_b_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: three parameterisations share stimulus and are
// checked every cycle against an array-based reference model.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic        En;
  logic        EnW;
  logic [3:0]  RA, RB, RW;
  logic [15:0] BusW;

  logic [15:0] a0, b0, a1, b1, a2, b2;
  logic        y0, y1, y2;

  regfile_param u0 (
    .clk(clk), .rst(rst), .En(En), .RA(RA), .RB(RB), .RW(RW),
    .EnW(EnW), .BusW(BusW), .BusA(a0), .BusB(b0), .init_busy(y0)
  );

  regfile_param #(
    .NUM_REGS(12), .BYPASS(0), .ZERO_REG(1)
  ) u1 (
    .clk(clk), .rst(rst), .En(En), .RA(RA), .RB(RB), .RW(RW),
    .EnW(EnW), .BusW(BusW), .BusA(a1), .BusB(b1), .init_busy(y1)
  );

  regfile_param #(
    .BYPASS(0)
  ) u2 (
    .clk(clk), .rst(rst), .En(En), .RA(RA), .RB(RB), .RW(RW),
    .EnW(EnW), .BusW(BusW), .BusA(a2), .BusB(b2), .init_busy(y2)
  );

  int nregs [3] = '{16, 12, 16};
  bit byp   [3] = '{1'b1, 1'b0, 1'b0};
  bit zr    [3] = '{1'b0, 1'b1, 1'b0};

  logic [15:0] mem [3][16];
  int          midx  [3];
  bit          minit [3];
  bit          mbusy [3];
  logic [15:0] ma [3];
  logic [15:0] mb [3];
  bit          mvalid;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];

  int checks;
  int failures;
  int cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit wr_ok(int c, bit ew, int w_a);
    return ew && (w_a < nregs[c]) && !(zr[c] && w_a == 0);
  endfunction

  function automatic logic [15:0] rd_m(int c, int x, bit ew,
                                       int w_a, logic [15:0] wd);
    if (x >= nregs[c]) return 16'h0;
    if (zr[c] && x == 0) return 16'h0;
    if (byp[c] && wr_ok(c, ew, w_a) && w_a == x) return wd;
    return mem[c][x];
  endfunction

  task automatic step(input bit r, input bit e, input bit ew,
                      input int a, input int b, input int w_a,
                      input logic [15:0] wd);
    logic [32:0] ex [3];
    rst  = r;
    En   = e;
    EnW  = ew;
    RA   = 4'(a);
    RB   = 4'(b);
    RW   = 4'(w_a);
    BusW = wd;
    for (int c = 0; c < 3; c++) begin
      if (r) begin
        minit[c] = 1'b1;
        midx[c]  = 0;
        mbusy[c] = 1'b1;
        ma[c]    = 16'h0;
        mb[c]    = 16'h0;
      end else if (minit[c]) begin
        mem[c][midx[c]] = (zr[c] && midx[c] == 0) ? 16'h0
                        : 16'(midx[c] + 1);
        midx[c]++;
        if (midx[c] == nregs[c]) begin
          minit[c] = 1'b0;
          mbusy[c] = 1'b0;
        end
      end else begin
        if (e) begin
          ma[c] = rd_m(c, a, ew, w_a, wd);
          mb[c] = rd_m(c, b, ew, w_a, wd);
        end
        if (wr_ok(c, ew, w_a)) mem[c][w_a] = wd;
      end
      ex[c] = {mbusy[c], ma[c], mb[c]};
    end
    if (r) mvalid = 1'b1;
    @(posedge clk);
    if (mvalid) begin
      q0.push_back(ex[0]);
      q1.push_back(ex[1]);
      q2.push_back(ex[2]);
    end
    #1;
  endtask

  task automatic chk(input int d, input logic [32:0] got,
                     input logic [32:0] exp);
    checks += 3;
    if (got[32] !== exp[32]) begin
      failures++;
      $display("FAIL d%0d init_busy cyc=%0d got=%b exp=%b",
               d, cyc, got[32], exp[32]);
    end
    if (got[31:16] !== exp[31:16]) begin
      failures++;
      $display("FAIL d%0d BusA cyc=%0d got=%h exp=%h",
               d, cyc, got[31:16], exp[31:16]);
    end
    if (got[15:0] !== exp[15:0]) begin
      failures++;
      $display("FAIL d%0d BusB cyc=%0d got=%h exp=%h",
               d, cyc, got[15:0], exp[15:0]);
    end
  endtask

  // Monitor: outputs are registered, so one expectation per edge.
  always @(negedge clk) begin
    cyc++;
    if (q0.size() > 0) chk(0, {y0, a0, b0}, q0.pop_front());
    if (q1.size() > 0) chk(1, {y1, a1, b1}, q1.pop_front());
    if (q2.size() > 0) chk(2, {y2, a2, b2}, q2.pop_front());
  end

  initial begin
    int ra_r, rb_r, rw_r;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    mvalid   = 1'b0;
    rst = 1'b1; En = 1'b0; EnW = 1'b0;
    RA = '0; RB = '0; RW = '0; BusW = '0;

    step(1, 1, 1, 2, 3, 4, 16'h5555);
    step(1, 0, 1, 1, 1, 1, 16'h7777);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 3, 0, 3, 16'hAAAA);

    step(0, 1, 0, 0, 15, 0, 16'h0);
    step(0, 1, 0, 3, 11, 0, 16'h0);
    step(0, 1, 1, 5, 5, 5, 16'hBEEF);
    step(0, 1, 0, 5, 5, 0, 16'h0);
    step(0, 0, 1, 7, 9, 7, 16'h1234);
    step(0, 0, 0, 3, 4, 0, 16'h0);
    step(0, 1, 0, 7, 9, 0, 16'h0);
    step(0, 0, 1, 0, 0, 13, 16'h1234);
    step(0, 1, 0, 13, 12, 0, 16'h0);
    step(0, 1, 0, 14, 15, 0, 16'h0);
    step(0, 0, 1, 0, 0, 0, 16'hFFFF);
    step(0, 1, 0, 0, 1, 0, 16'h0);

    step(1, 0, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 7; i++) step(0, 1, 1, i, i, i, 16'h9999);
    step(1, 1, 1, 2, 2, 2, 16'h4242);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 6, 6, 6, 16'h1111);
    for (int i = 0; i < 16; i++) step(0, 1, 0, i, 15 - i, 0, 16'h0);

    for (int n = 0; n < 3000; n++) begin
      ra_r = int'($urandom_range(0, 15));
      rb_r = ($urandom_range(0, 7) == 0) ? ra_r
           : int'($urandom_range(0, 15));
      rw_r = ($urandom_range(0, 3) == 0) ? ra_r
           : int'($urandom_range(0, 15));
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1),
           ra_r, rb_r, rw_r, 16'($urandom));
    end

    step(0, 0, 0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 0, 0, 16'h0);
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0",
               q0.size() + q1.size() + q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
